// File: rtl/egress_tx_fifo_pkg.sv
// egress_tx_fifo_pkg
// Shared fabric-side types for the egress TX FIFO slice:
//   fabric_word_t  - 32-bit big-endian fabric word (byte 0 in [31:24])
//   bytes_valid_t  - valid-byte count of a word, 1..4
//   len_entry_t    - length-FIFO entry {word_count, last_bytes}
//   tx_state_t     - read-side FSM states
package egress_tx_fifo_pkg;

   typedef logic [31:0] fabric_word_t;
   typedef logic [2:0]  bytes_valid_t;

   // Wide enough for any power-of-two DEPTH up to 32768 words.
   localparam int unsigned WORD_COUNT_W = 16;
   typedef logic [WORD_COUNT_W-1:0] word_count_t;

   typedef struct packed {
      word_count_t  word_count;
      bytes_valid_t last_bytes;
   } len_entry_t;

   localparam bytes_valid_t FULL_WORD_BYTES = 3'd4;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA
   } tx_state_t;

endpackage

// File: rtl/egress_tx_fifo_if.sv
// egress_tx_fifo_if
// Fabric write bus and MAC transmit bus of the egress TX FIFO.
//   master : fabric/MAC side (drives wr_*, tx_ready)
//   slave  : the FIFO (drives wr_space, wr_overflow, tx_*)
// Parameter DEPTH sizes wr_space ($clog2(DEPTH)+1 bits).
interface egress_tx_fifo_if #(
   parameter int unsigned DEPTH = 4096
);
   import egress_tx_fifo_pkg::*;

   localparam int unsigned SPACE_W = $clog2(DEPTH) + 1;

   logic               wr_start;
   logic               wr_valid;
   fabric_word_t       wr_data;
   bytes_valid_t       wr_bytes;
   logic               wr_commit;
   logic               wr_drop;
   logic [SPACE_W-1:0] wr_space;
   logic               wr_overflow;
   logic               tx_ready;
   logic               tx_start;
   logic               tx_data_valid;
   bytes_valid_t       tx_bytes_valid;
   fabric_word_t       tx_data;

   modport master (
      output wr_start, wr_valid, wr_data, wr_bytes, wr_commit, wr_drop, tx_ready,
      input  wr_space, wr_overflow, tx_start, tx_data_valid, tx_bytes_valid, tx_data
   );

   modport slave (
      input  wr_start, wr_valid, wr_data, wr_bytes, wr_commit, wr_drop, tx_ready,
      output wr_space, wr_overflow, tx_start, tx_data_valid, tx_bytes_valid, tx_data
   );

endinterface

// File: rtl/egress_length_fifo.sv
// egress_length_fifo
// Single-clock synchronous FIFO of committed-frame length entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/push_data : enqueue (ignored when full)
//   pop/pop_data   : dequeue; pop_data is registered, valid the cycle after pop
//   full, empty    : occupancy flags
module egress_length_fifo
   import egress_tx_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  len_entry_t push_data,
   input  logic       pop,
   output len_entry_t pop_data,
   output logic       full,
   output logic       empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   typedef logic [AW:0] ptr_t;
   localparam ptr_t PTR_ONE = (AW+1)'(1);

   len_entry_t mem [DEPTH];
   ptr_t       wr_ptr;
   ptr_t       rd_ptr;

   // Extra MSB tells full (MSBs differ) from empty (pointers equal).
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop && !empty)
            rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pop_data <= '0;
      else if (pop && !empty)
         pop_data <= mem[rd_ptr[AW-1:0]];
   end

endmodule

// File: rtl/egress_tx_fifo.sv
// egress_tx_fifo
// Per-port egress frame buffer: the fabric writes whole frames and commits or
// drops them at their end; committed frames are replayed in order to the MAC
// as a tx_start strobe followed by a gap-free burst of data words.
//   clk, rst_n : fabric clock, asynchronous active-low reset
//   bus        : egress_tx_fifo_if.slave (write bus, space/overflow, TX bus)
//   stat_frames_sent, stat_frames_dropped : saturating counters, present only
//                when EGRESS_TX_FIFO_STATS_EN is defined
// Parameters: DEPTH (packet words, power of two), MAX_FRAMES (committed
// frames outstanding, power of two).
module egress_tx_fifo
   import egress_tx_fifo_pkg::*;
#(
   parameter int unsigned DEPTH      = 4096,
   parameter int unsigned MAX_FRAMES = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   egress_tx_fifo_if.slave     bus
`ifdef EGRESS_TX_FIFO_STATS_EN
   ,
   output logic [31:0]         stat_frames_sent,
   output logic [31:0]         stat_frames_dropped
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   typedef logic [PW-1:0] ptr_t;
   localparam ptr_t PTR_ONE = PW'(1);
   localparam ptr_t DEPTH_P = PW'(DEPTH);

   // Write side state
   ptr_t         cmt_ptr;
   ptr_t         tent_ptr;
   ptr_t         rd_ptr;
   logic         frame_bad;
   bytes_valid_t last_bytes_q;
   logic         wr_overflow_q;
   ptr_t         wr_space_q;

   // Write side combinational
   ptr_t         base_ptr;
   logic         base_bad;
   logic         mem_full;
   logic         wr_accept;
   ptr_t         tent_next_c;
   logic         bad_next_c;
   bytes_valid_t last_bytes_c;
   ptr_t         frame_words;
   logic         commit_ok;
   logic         commit_reject;
   ptr_t         cmt_next_c;
   ptr_t         rd_next_c;

   // Length FIFO
   len_entry_t   lf_push_data;
   len_entry_t   lf_dout;
   logic         lf_full;
   logic         lf_empty;
   logic         lf_pop;

   // Read side
   tx_state_t    state;
   tx_state_t    state_next;
   logic         mem_rd;
   word_count_t  words_left;
   bytes_valid_t tx_last_bytes;
   logic         last_word;

   fabric_word_t pkt_mem [DEPTH];
   fabric_word_t mem_dout;

   // wr_start rebases the frame on the committed pointer so a word presented
   // with it becomes word 0 of the new frame; same-cycle wr_valid counts
   // toward a same-cycle commit.
   always_comb begin
      base_ptr      = bus.wr_start ? cmt_ptr : tent_ptr;
      base_bad      = bus.wr_start ? 1'b0 : frame_bad;
      mem_full      = ((base_ptr - rd_ptr) == DEPTH_P);
      wr_accept     = bus.wr_valid && !mem_full && !base_bad;
      tent_next_c   = wr_accept ? (base_ptr + PTR_ONE) : base_ptr;
      bad_next_c    = base_bad || (bus.wr_valid && mem_full);
      last_bytes_c  = bus.wr_valid ? bus.wr_bytes : last_bytes_q;
      frame_words   = tent_next_c - cmt_ptr;
      commit_reject = bus.wr_commit && !bus.wr_drop &&
                      (bad_next_c || ((frame_words != '0) && lf_full));
      commit_ok     = bus.wr_commit && !bus.wr_drop && !bad_next_c &&
                      (frame_words != '0) && !lf_full;
      cmt_next_c    = commit_ok ? tent_next_c : cmt_ptr;
      rd_next_c     = mem_rd ? (rd_ptr + PTR_ONE) : rd_ptr;
      lf_push_data  = '{word_count: word_count_t'(frame_words), last_bytes: last_bytes_c};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmt_ptr       <= '0;
         tent_ptr      <= '0;
         rd_ptr        <= '0;
         frame_bad     <= 1'b0;
         last_bytes_q  <= '0;
         wr_overflow_q <= 1'b0;
         wr_space_q    <= DEPTH_P;
      end else begin
         last_bytes_q  <= last_bytes_c;
         wr_overflow_q <= commit_reject;
         rd_ptr        <= rd_next_c;
         wr_space_q    <= DEPTH_P - (cmt_next_c - rd_next_c);
         if (bus.wr_drop || commit_reject) begin
            tent_ptr  <= cmt_ptr;
            frame_bad <= 1'b0;
         end else if (commit_ok) begin
            tent_ptr  <= tent_next_c;
            cmt_ptr   <= tent_next_c;
            frame_bad <= 1'b0;
         end else begin
            // Zero-word commits land here too: tent_next_c equals cmt_ptr.
            tent_ptr  <= tent_next_c;
            frame_bad <= bad_next_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_accept)
         pkt_mem[base_ptr[AW-1:0]] <= bus.wr_data;
      if (mem_rd)
         mem_dout <= pkt_mem[rd_ptr[AW-1:0]];
   end

   egress_length_fifo #(
      .DEPTH (MAX_FRAMES)
   ) u_length_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (commit_ok),
      .push_data (lf_push_data),
      .pop       (lf_pop),
      .pop_data  (lf_dout),
      .full      (lf_full),
      .empty     (lf_empty)
   );

   assign last_word = (words_left == word_count_t'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= TX_IDLE;
      else
         state <= state_next;
   end

   // Word 0 is read in IDLE and held in mem_dout through START; each DATA
   // cycle then prefetches the next word so the burst has no gaps.
   always_comb begin
      state_next = state;
      lf_pop     = 1'b0;
      mem_rd     = 1'b0;
      case (state)
         TX_IDLE: begin
            if (!lf_empty && bus.tx_ready) begin
               lf_pop     = 1'b1;
               mem_rd     = 1'b1;
               state_next = TX_START;
            end
         end
         TX_START: state_next = TX_DATA;
         TX_DATA: begin
            if (last_word)
               state_next = TX_IDLE;
            else
               mem_rd = 1'b1;
         end
         default: state_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         words_left    <= '0;
         tx_last_bytes <= '0;
      end else if (state == TX_START) begin
         words_left    <= lf_dout.word_count;
         tx_last_bytes <= lf_dout.last_bytes;
      end else if (state == TX_DATA) begin
         words_left    <= words_left - word_count_t'(1);
      end
   end

   assign bus.tx_start       = (state == TX_START);
   assign bus.tx_data_valid  = (state == TX_DATA);
   assign bus.tx_bytes_valid = (state == TX_DATA) ?
                               (last_word ? tx_last_bytes : FULL_WORD_BYTES) : '0;
   assign bus.tx_data        = (state == TX_DATA) ? mem_dout : '0;
   assign bus.wr_space       = wr_space_q;
   assign bus.wr_overflow    = wr_overflow_q;

`ifdef EGRESS_TX_FIFO_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_frames_sent    <= '0;
         stat_frames_dropped <= '0;
      end else begin
         if (bus.tx_start && (stat_frames_sent != '1))
            stat_frames_sent <= stat_frames_sent + 32'd1;
         if (wr_overflow_q && (stat_frames_dropped != '1))
            stat_frames_dropped <= stat_frames_dropped + 32'd1;
      end
   end
`endif

endmodule
